// File: rtl/qpsk_dump_scheduler.sv
// qpsk_dump_scheduler: symbol-timing controller for the QPSK integrate-and-dump demodulator.
// Issues I/Q dump strobes (Q half a symbol after I), pairs decisions into symbols, applies +/-1 sample phase steps.
module qpsk_dump_scheduler #(
   parameter int SPS        = 8,
   parameter int ALIGN_SYMS = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             smp_valid,
   input  logic [1:0]       phase_adj,
   output logic             dump_i,
   output logic             dump_q,
   input  logic             i_dec,
   input  logic             q_dec,
   output logic             sym_valid,
   output logic             sym_i,
   output logic             sym_q,
   input  logic             sym_ready,
   output logic             overflow,
   output logic [CNT_W-1:0] sym_count,
   output logic [1:0]       state
);
   localparam int PW = $clog2(SPS);
   localparam int AW = $clog2(ALIGN_SYMS + 1);
   typedef enum logic [1:0] {IDLE = 2'd0, ALIGN = 2'd1, RUN = 2'd2} state_t;
   state_t           r_state, w_state_nx;
   logic [PW-1:0]    r_cnt;
   logic [AW-1:0]    r_align_cnt;
   logic             r_skip, r_i_have, r_i_hold, r_di_d, r_dq_d;
   logic             r_sym_valid, r_sym_i, r_sym_q, r_overflow;
   logic [CNT_W-1:0] r_sym_count;
   logic             w_act, w_flush, w_last, w_wrap, w_half, w_new, w_xfer, w_run;
   always_comb begin
      w_act   = r_state != IDLE;
      w_run   = r_state == RUN && en;
      w_flush = r_state == IDLE && en;
      w_last  = r_cnt == PW'(SPS - 1);
      w_wrap  = w_act && smp_valid && w_last;
      w_half  = w_act && smp_valid && r_cnt == PW'(SPS / 2 - 1);
      w_new   = r_dq_d && r_i_have;
      w_xfer  = r_sym_valid && sym_ready;
      w_state_nx = r_state;
      if (!en) w_state_nx = IDLE;
      else if (r_state == IDLE) w_state_nx = ALIGN;
      else if (r_state == ALIGN && w_half && r_align_cnt == AW'(ALIGN_SYMS - 1)) w_state_nx = RUN;
   end
   assign dump_i    = w_flush | w_wrap;
   assign dump_q    = w_flush | w_half;
   assign sym_valid = r_sym_valid;
   assign sym_i     = r_sym_i;
   assign sym_q     = r_sym_q;
   assign overflow  = r_overflow;
   assign sym_count = r_sym_count;
   assign state     = r_state;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else r_state <= w_state_nx;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_align_cnt <= '0;
         r_skip      <= 1'b0;
         r_i_have    <= 1'b0;
         r_i_hold    <= 1'b0;
         r_di_d      <= 1'b0;
         r_dq_d      <= 1'b0;
         r_sym_valid <= 1'b0;
         r_sym_i     <= 1'b0;
         r_sym_q     <= 1'b0;
         r_overflow  <= 1'b0;
         r_sym_count <= '0;
      end else begin
         // decisions arrive one cycle after their dump; only RUN dumps are kept
         r_di_d <= w_wrap && w_run;
         r_dq_d <= w_half && w_run;
         if (w_xfer) r_sym_count <= r_sym_count + CNT_W'(1);
         if (!en) begin
            r_cnt       <= '0;
            r_skip      <= 1'b0;
            r_i_have    <= 1'b0;
            r_sym_valid <= 1'b0;
         end else if (r_state == IDLE) begin
            r_cnt       <= '0;
            r_skip      <= 1'b0;
            r_i_have    <= 1'b0;
            r_align_cnt <= '0;
            r_overflow  <= 1'b0;
         end else begin
            // retard holds cnt at 0 for one extra sample via r_skip
            if (smp_valid) begin
               if (w_last) begin
                  r_cnt  <= (phase_adj == 2'b01) ? PW'(1) : '0;
                  r_skip <= phase_adj == 2'b10;
               end else if (r_skip) r_skip <= 1'b0;
               else r_cnt <= r_cnt + PW'(1);
            end
            if (r_state == ALIGN && w_half) r_align_cnt <= r_align_cnt + AW'(1);
            if (r_di_d) begin
               r_i_hold <= i_dec;
               r_i_have <= 1'b1;
            end else if (w_new) r_i_have <= 1'b0;
            if (w_new && (!r_sym_valid || sym_ready)) begin
               r_sym_i     <= r_i_hold;
               r_sym_q     <= q_dec;
               r_sym_valid <= 1'b1;
            end else if (w_new) r_overflow <= 1'b1;
            else if (w_xfer) r_sym_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_qpsk_dump_scheduler.sv
// tb_qpsk_dump_scheduler: directed bench with a behavioural scoreboard for dump timing,
// symbol pairing, phase correction, backpressure and enable sequencing.
module tb_qpsk_dump_scheduler;
   localparam int SPS = 8;
   localparam int AS  = 2;
   localparam int CW  = 16;
   logic          clk = 0, rst_n = 1, en = 0, smp_valid = 0, i_dec = 0, q_dec = 0, sym_ready = 0;
   logic [1:0]    phase_adj = 2'b00;
   logic          dump_i, dump_q, sym_valid, sym_i, sym_q, overflow;
   logic [CW-1:0] sym_count;
   logic [1:0]    state;
   int            npass = 0, nfail = 0, ntot = 0;
   int            cyc = 0, gap = 0, ndump = 0;
   logic          pat_i = 0, pat_q = 0, d_i = 0, d_q = 0, s_v = 0;
   int            m_st = 0, m_aq = 0, m_cnt = 0;
   logic          m_pend = 0, m_ov = 0, m_ih = 0, m_hold = 0, pdi = 0, pdq = 0;
   logic [1:0]    sb[$];

   always #5 clk = ~clk;

   qpsk_dump_scheduler #(.SPS(SPS), .ALIGN_SYMS(AS), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .smp_valid(smp_valid), .phase_adj(phase_adj),
      .dump_i(dump_i), .dump_q(dump_q), .i_dec(i_dec), .q_dec(q_dec),
      .sym_valid(sym_valid), .sym_i(sym_i), .sym_q(sym_q), .sym_ready(sym_ready),
      .overflow(overflow), .sym_count(sym_count), .state(state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // observe one cycle at the falling edge, advance the model, then drive the next cycle
   task automatic step();
      logic xf, nw;
      @(negedge clk);
      d_i = dump_i;
      d_q = dump_q;
      s_v = smp_valid;
      if (d_i || d_q) ndump++;
      chk("state", 32'(state), m_st);
      chk("sym_valid", 32'(sym_valid), 32'(m_pend));
      chk("overflow", 32'(overflow), 32'(m_ov));
      chk("sym_count", 32'(sym_count), m_cnt % 65536);
      if (m_st == 0) chk("idle_dumps", 32'({d_i, d_q}), 32'({en, en}));
      else if (!s_v) chk("gap_dumps", 32'({d_i, d_q}), 0);
      xf = m_pend && sym_ready;
      if (xf) begin
         chk("sym_data", 32'({sym_i, sym_q}), 32'(sb.pop_front()));
         m_cnt++;
      end
      nw = en && pdq && m_ih;
      if (pdi) begin
         m_ih   = 1'b1;
         m_hold = i_dec;
      end else if (pdq) m_ih = 1'b0;
      if (nw && (!m_pend || sym_ready)) begin
         sb.push_back({m_hold, q_dec});
         m_pend = 1'b1;
      end else if (nw) m_ov = 1'b1;
      else if (xf) m_pend = 1'b0;
      pdi = d_i && m_st == 2 && en;
      pdq = d_q && m_st == 2 && en;
      if (!en) begin
         m_st = 0;
         m_pend = 1'b0;
         m_ih = 1'b0;
         sb.delete();
      end else if (m_st == 0) begin
         m_st = 1;
         m_aq = 0;
         m_ov = 1'b0;
      end else if (m_st == 1 && d_q) begin
         m_aq++;
         if (m_aq == AS) m_st = 2;
      end
      @(posedge clk);
      #1;
      cyc++;
      i_dec = d_i ? pat_i : ~pat_i;
      q_dec = d_q ? pat_q : ~pat_q;
      smp_valid = gap == 1 || (gap == 3 && cyc % 3 == 0);
   endtask

   task automatic wait_d(input bit q, output int n);
      n = 0;
      for (int k = 0; k < 300; k++) begin
         step();
         if (s_v) n++;
         if (q ? d_q : d_i) return;
      end
      ntot++;
      nfail++;
      $error("FAIL dump_timeout: observed no dump (q=%0d) expected one within 300 cycles", q);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: observed no end of test expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, c0, cb;
      #2 rst_n = 0;
      repeat (3) step();
      chk("rst_dump", 32'({dump_i, dump_q}), 0);
      chk("rst_sym", 32'({sym_valid, sym_i, sym_q, overflow}), 0);
      chk("rst_cnt", 32'(sym_count), 0);
      rst_n = 1;
      gap = 1;
      ndump = 0;
      repeat (50) step();
      chk("idle_no_dump", ndump, 0);
      chk("idle_state", 32'(state), 0);

      en = 1;
      sym_ready = 1;
      step();
      chk("flush", 32'({d_i, d_q}), 3);
      wait_d(1, n);
      chk("align_q1_spacing", n, 4);
      chk("align_state", 32'(state), 1);
      wait_d(0, n);
      chk("align_i_spacing", n, 4);
      wait_d(1, n);
      chk("align_q2_spacing", n, 4);
      chk("run_state", 32'(state), 2);

      for (int p = 0; p < 4; p++) begin
         pat_i = p[1];
         pat_q = p[0];
         wait_d(0, n);
         chk("i_spacing", n, 4);
         wait_d(1, n);
         chk("q_offset", n, 4);
      end
      repeat (3) step();
      chk("count4", 32'(sym_count), 4);
      chk("sb_drained", sb.size(), 0);

      pat_i = 1;
      pat_q = 1;
      phase_adj = 2'b01;
      wait_d(0, n);
      phase_adj = 2'b00;
      wait_d(0, n);
      chk("adv_window", n, 7);
      phase_adj = 2'b10;
      wait_d(0, n);
      phase_adj = 2'b00;
      wait_d(0, n);
      chk("ret_window", n, 9);
      phase_adj = 2'b11;
      wait_d(0, n);
      phase_adj = 2'b00;
      wait_d(0, n);
      chk("none_window", n, 8);

      wait_d(1, n);
      repeat (3) step();
      cb = m_cnt;
      sym_ready = 0;
      pat_i = 1;
      pat_q = 0;
      wait_d(0, n);
      wait_d(1, n);
      pat_i = 0;
      pat_q = 1;
      wait_d(0, n);
      wait_d(1, n);
      repeat (3) step();
      chk("bp_overflow", 32'(overflow), 1);
      chk("bp_valid", 32'(sym_valid), 1);
      chk("bp_held", 32'({sym_i, sym_q}), 2);
      chk("bp_count_hold", 32'(sym_count), cb % 65536);
      sym_ready = 1;
      step();
      step();
      chk("bp_count_inc", 32'(sym_count), (cb + 1) % 65536);
      chk("bp_ov_sticky", 32'(overflow), 1);

      gap = 3;
      wait_d(0, n);
      c0 = cyc;
      wait_d(1, n);
      chk("gap_iq_cycles", cyc - c0, 12);
      wait_d(0, n);
      chk("gap_sym_cycles", cyc - c0, 24);
      repeat (5) step();
      en = 0;
      step();
      chk("abort_state", 32'(state), 0);
      chk("abort_valid", 32'(sym_valid), 0);
      chk("abort_ov_hold", 32'(overflow), 1);

      gap = 1;
      repeat (4) step();
      en = 1;
      step();
      chk("reflush", 32'({d_i, d_q}), 3);
      wait_d(1, n);
      chk("realign_q1", n, 4);
      chk("realign_state", 32'(state), 1);
      chk("realign_ov_clr", 32'(overflow), 0);
      wait_d(0, n);
      wait_d(1, n);
      chk("rerun_state", 32'(state), 2);
      pat_i = 0;
      pat_q = 1;
      wait_d(0, n);
      wait_d(1, n);
      repeat (4) step();
      chk("final_drained", sb.size(), 0);
      chk("final_count", 32'(sym_count), m_cnt % 65536);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule

// File: doc/qpsk_dump_scheduler.md
Name: qpsk_dump_scheduler

Overview:
- Symbol-timing controller for the QPSK integrate-and-dump demodulator.
- Counts filtered-sample strobes and issues dump/clear strobes to the I and Q integrators. The Q dump is offset by half a symbol from the I dump.
- Collects the integrators' hard-decision bits into I/Q symbol pairs and delivers them downstream on a valid/ready handshake.
- Provides align/run sequencing and ±1-sample phase correction driven by a timing-recovery loop.

Parameters:
SPS, 8, samples per symbol; even, ≥4
ALIGN_SYMS, 2, symbols discarded after enable before output starts; ≥1
CNT_W, 16, width of sym_count

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  demodulator enable, level
smp_valid  in  1  one filtered I/Q sample present this cycle
phase_adj  in  2  01 advance, 10 retard, 00/11 none; sampled at I boundary
dump_i  out  1  one-cycle strobe: I integrator decides and clears
dump_q  out  1  one-cycle strobe: Q integrator decides and clears
i_dec  in  1  I decision; valid the cycle after dump_i
q_dec  in  1  Q decision; valid the cycle after dump_q
sym_valid  out  1  symbol output valid
sym_i  out  1  I bit of symbol
sym_q  out  1  Q bit of symbol
sym_ready  in  1  downstream accepts when sym_valid & sym_ready
overflow  out  1  sticky: a symbol was dropped
sym_count  out  CNT_W  accepted symbols, wraps
state  out  2  0 IDLE, 1 ALIGN, 2 RUN

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, skip=0, i_have=0, align_cnt=0. All outputs 0.
- Phase counter cnt, range 0..SPS-1:
  - Advances only on smp_valid in ALIGN or RUN.
  - dump_i = smp_valid & cnt==SPS-1 (combinational from registered cnt).
  - dump_q = smp_valid & cnt==SPS/2-1.
- Wrap at cnt==SPS-1 with smp_valid:
  - phase_adj=01: next cnt=1 (next window SPS-1 samples).
  - phase_adj=10: next cnt=0 and skip=1; the next smp_valid leaves cnt at 0 and clears skip (window SPS+1).
  - Otherwise: next cnt=0.
  - phase_adj is ignored at all other cycles.
- IDLE:
  - No dumps, sym_valid=0.
  - en=1 moves to ALIGN, and in that transition cycle asserts dump_i=dump_q=1 for one cycle (flush). Decisions resulting from the flush are ignored.
  - On the same transition: cnt=0, align_cnt=0, overflow cleared.
- ALIGN:
  - Dumps run normally; decisions are discarded.
  - Each dump_q increments align_cnt. On the dump_q that brings align_cnt to ALIGN_SYMS, go to RUN.
- RUN:
  - Cycle after dump_i: i_hold=i_dec, i_have=1.
  - Cycle after dump_q with i_have=1: a new symbol {i_hold, q_dec} is formed and i_have is cleared.
  - A dump_q with i_have=0 (the first Q after entry) is discarded.
- Output register, single stage:
  - New symbol with (sym_valid=0) or (sym_valid & sym_ready): load it, sym_valid=1.
  - New symbol with sym_valid & !sym_ready: drop the new symbol, set overflow, hold the old symbol.
  - sym_valid & sym_ready with no new symbol: sym_valid=0.
  - Each accepted transfer increments sym_count, modulo 2^CNT_W.
- en=0 in any state: next cycle state=IDLE, cnt=0, skip=0, i_have=0, sym_valid=0 (pending symbol dropped, not counted). overflow and sym_count hold until the next IDLE→ALIGN (sym_count only clears on reset).
- Latency: sym_valid rises 2 cycles after the dump_q cycle (decision cycle + register).
- Simultaneous events:
  - dump_i and dump_q cannot coincide, since SPS/2-1 ≠ SPS-1.
  - A flush pulse coinciding with an en drop is suppressed by IDLE priority.
  - Async reset mid-symbol returns everything to the reset values immediately.

Test Plan:
- Reset/idle: rst_n low then high, en=0, smp_valid every cycle for 50 cycles -> no dump strobes, all outputs 0, state=0.
- Enable and align (SPS=8, smp_valid=1 every cycle): en rises -> flush dump_i=dump_q=1 in the transition cycle. Then dump_q at cnt 3, dump_i at cnt 7. state=2 after the 2nd dump_q. First sym_valid follows the first full I→Q pair in RUN.
- Symbol pairing: drive i_dec=1 after dump_i and q_dec=0 after the following dump_q, sym_ready=1 -> sym_i=1, sym_q=0, sym_valid pulse 2 cycles after dump_q, sym_count increments by 1. Repeat for patterns 00, 01, 10, 11.
- Phase adjust: phase_adj=01 at a wrap -> next dump_i exactly 7 samples later. phase_adj=10 -> 9 samples later. phase_adj=11 -> 8 samples later.
- Backpressure: sym_ready=0 across two symbols -> first symbol held, second dropped, overflow=1, sym_count unchanged. Then sym_ready=1 -> first symbol accepted, count +1. overflow stays 1 until en toggles.
- Gapped samples and abort: smp_valid every 3rd cycle -> dump spacing 24 cycles. Drop en mid-symbol -> sym_valid=0 and state=0 next cycle. Re-enable -> flush pulse and full ALIGN repeated.
